// File: rtl/quickq_pkg.sv
`default_nettype none
// ============================================================================
// quickq_pkg : shared op, state and response-entry types for quickq_sched
// Rev 1.0
// ============================================================================
package quickq_pkg;

    // Wide enough for any practical requester count; the top narrows it back.
    localparam int ID_MAX_W = 8;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                is_deq;
        logic                err;
    } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/quickq_sched_arb.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin pick, first valid request above the pointer
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   idx_o
);

    always_comb begin : p_pick
        int   k;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        // Offset 1 first so the last winner has lowest priority.
        for (int off = 1; off <= N_REQ; off++) begin
            k = (int'(ptr_i) + off) % N_REQ;
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IDW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/quickq_sched.sv
`default_nettype none
// ============================================================================
// quickq_sched : round-robin op scheduler, occupancy tracker and response
//                sequencer in front of the systolic quickNode chain
// Rev 1.0
// ============================================================================
module quickq_sched
    import quickq_pkg::*;
#(
    parameter  int N_REQ      = 2,
    parameter  int DW         = 16,
    parameter  int CAPACITY   = 64,
    parameter  int ISSUE_GAP  = 2,
    parameter  int DEQ_LAT    = 3,
    parameter  int CLR_CYCLES = 8,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW         = $clog2(CAPACITY + 1)
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ-1:0]    req_op_i,
    input  logic [N_REQ*DW-1:0] req_data_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic                enq_o,
    output logic                deq_o,
    output logic [DW-1:0]       data_o,
    output logic                chain_reset_o,
    input  logic [DW-1:0]       chain_data_i,
    output logic                rsp_valid_o,
    output logic [IDW-1:0]      rsp_id_o,
    output logic                rsp_err_o,
    output logic [DW-1:0]       rsp_data_o,
    output logic [CW-1:0]       count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                busy_o
);

    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int RW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_e                   state_q;
    logic [RW-1:0]            clr_cnt_q;
    logic [GW-1:0]            gap_cnt_q;
    logic [CW-1:0]            count_q, count_d;
    logic [IDW-1:0]           ptr_q;
    rsp_entry_t [DEQ_LAT-1:0] line_q;
    rsp_entry_t               entry_d, head;

    logic             grant_en, granted, op_deq, op_err, full, empty;
    logic [N_REQ-1:0] arb_req, arb_grant;
    logic [IDW-1:0]   arb_idx;

    // A grant coinciding with clear or reset is suppressed.
    assign grant_en = (state_q == ST_IDLE) && !clear_i && !reset_i;
    assign arb_req  = req_valid_i & {N_REQ{grant_en}};

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    assign granted = |arb_grant;
    assign op_deq  = (op_e'(req_op_i[arb_idx]) == OP_DEQ);
    assign full    = (count_q == CW'(CAPACITY));
    assign empty   = (count_q == '0);
    assign op_err  = op_deq ? empty : full;

    assign grant_o = arb_grant;
    assign enq_o   = granted && !op_deq && !op_err;
    assign deq_o   = granted && op_deq && !op_err;
    assign data_o  = enq_o ? req_data_i[int'(arb_idx)*DW +: DW] : '0;

    always_comb begin
        count_d = count_q;
        if (enq_o) begin
            count_d = count_q + CW'(1);
        end else if (deq_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        entry_d = '0;
        if (granted) begin
            entry_d.valid  = 1'b1;
            entry_d.id     = ID_MAX_W'(arb_idx);
            entry_d.is_deq = op_deq;
            entry_d.err    = op_err;
        end
    end

    assign head          = line_q[DEQ_LAT-1];
    assign rsp_valid_o   = head.valid;
    assign rsp_id_o      = IDW'(head.id);
    assign rsp_err_o     = head.valid && head.err;
    assign rsp_data_o    = (head.valid && head.is_deq && !head.err) ? chain_data_i : '0;
    assign count_o       = count_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign busy_o        = (state_q != ST_IDLE);
    assign chain_reset_o = (state_q == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (reset_i || clear_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            gap_cnt_q <= '0;
            count_q   <= '0;
            line_q    <= '0;
            if (reset_i) begin
                ptr_q <= IDW'(N_REQ - 1);
            end
        end else begin
            count_q   <= count_d;
            line_q[0] <= entry_d;
            for (int i = 1; i < DEQ_LAT; i++) begin
                line_q[i] <= line_q[i-1];
            end
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == RW'(CLR_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + RW'(1);
                    end
                end
                ST_IDLE: begin
                    if (granted) begin
                        ptr_q <= arb_idx;
                        if (ISSUE_GAP > 1) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GW'(ISSUE_GAP - 2)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quickq_sched.sv
`default_nettype none
// ============================================================================
// tb_quickq_sched : directed table, corner sequences and random traffic
//                   against a cycle-timestamp reference model
// Rev 1.0
// ============================================================================
module tb_quickq_sched;

    localparam int N_REQ      = 2;
    localparam int DW         = 16;
    localparam int CAPACITY   = 64;
    localparam int ISSUE_GAP  = 2;
    localparam int DEQ_LAT    = 3;
    localparam int CLR_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset_i, clear_i;
    logic [1:0]  req_valid_i, req_op_i;
    logic [31:0] req_data_i;
    logic [15:0] chain_data_i;
    logic [1:0]  grant_o;
    logic        enq_o, deq_o, chain_reset_o, rsp_valid_o, rsp_id_o, rsp_err_o;
    logic        full_o, empty_o, busy_o;
    logic [15:0] data_o, rsp_data_o;
    logic [6:0]  count_o;

    always #5 clk = ~clk;

    quickq_sched #(
        .N_REQ(N_REQ), .DW(DW), .CAPACITY(CAPACITY), .ISSUE_GAP(ISSUE_GAP),
        .DEQ_LAT(DEQ_LAT), .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk(clk), .reset_i(reset_i), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_data_i(req_data_i),
        .grant_o(grant_o), .enq_o(enq_o), .deq_o(deq_o), .data_o(data_o),
        .chain_reset_o(chain_reset_o), .chain_data_i(chain_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
        .rsp_data_o(rsp_data_o), .count_o(count_o), .full_o(full_o),
        .empty_o(empty_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: occupancy, pointer, time stamps of when grants are
    // allowed again / when clear ends, and pending responses with due cycles.
    typedef struct {
        int due;
        int id;
        bit is_deq;
        bit err;
    } pend_t;

    pend_t m_q[$];
    int    m_cnt      = 0;
    int    m_ptr      = N_REQ - 1;
    int    m_ok_at    = 0;
    int    m_clr_end  = 0;
    bit    m_in_rst   = 1'b1;
    int    last_gnt   = -100;
    int    gnt_seen   = 0;
    int    rsp_seen   = 0;
    bit    last_grant = 1'b0;

    task automatic model_step();
        pend_t       p;
        int          g;
        bit          e_isdeq, e_err, e_enq, e_deq, e_rv, e_rerr;
        int          e_rid;
        logic [15:0] e_data, e_rdata;

        check("count_o", count_o, m_cnt);
        check("full_o", full_o, m_cnt == CAPACITY);
        check("empty_o", empty_o, m_cnt == 0);
        check("busy_o", busy_o, m_in_rst || cyc < m_ok_at);
        check("chain_reset_o", chain_reset_o, m_in_rst || cyc < m_clr_end);

        e_rv = 1'b0; e_rid = 0; e_rerr = 1'b0; e_rdata = '0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            p       = m_q.pop_front();
            e_rv    = 1'b1;
            e_rid   = p.id;
            e_rerr  = p.err;
            e_rdata = (p.is_deq && !p.err) ? chain_data_i : 16'h0;
        end
        check("rsp_valid_o", rsp_valid_o, e_rv);
        check("rsp_id_o", rsp_id_o, e_rid);
        check("rsp_err_o", rsp_err_o, e_rerr);
        check("rsp_data_o", rsp_data_o, e_rdata);

        g = -1;
        if (!reset_i && !clear_i && !m_in_rst && cyc >= m_ok_at) begin
            for (int off = 1; off <= N_REQ; off++) begin
                int k;
                k = (m_ptr + off) % N_REQ;
                if (g < 0 && req_valid_i[k]) g = k;
            end
        end
        e_isdeq = 1'b0;
        e_data  = '0;
        if (g >= 0) e_isdeq = req_op_i[g];
        e_err = e_isdeq ? (m_cnt == 0) : (m_cnt == CAPACITY);
        e_enq = (g >= 0) && !e_isdeq && !e_err;
        e_deq = (g >= 0) && e_isdeq && !e_err;
        if (e_enq) e_data = req_data_i[g*DW +: DW];
        check("grant_o", grant_o, (g >= 0) ? (32'd1 << g) : 32'd0);
        check("enq_o", enq_o, e_enq);
        check("deq_o", deq_o, e_deq);
        check("data_o", data_o, e_data);

        last_grant = (grant_o != 2'b00);
        if (last_grant) begin
            check("grant_spacing", (cyc - last_gnt) >= ISSUE_GAP, 1);
            last_gnt = cyc;
            gnt_seen++;
        end
        if (rsp_valid_o) rsp_seen++;

        if (reset_i) begin
            m_in_rst = 1'b1;
            m_cnt    = 0;
            m_ptr    = N_REQ - 1;
            m_q.delete();
        end else begin
            if (m_in_rst) begin
                m_in_rst  = 1'b0;
                m_ok_at   = cyc + CLR_CYCLES;
                m_clr_end = cyc + CLR_CYCLES;
            end
            if (g >= 0) begin
                m_ptr   = g;
                m_ok_at = cyc + ISSUE_GAP;
                m_q.push_back('{cyc + DEQ_LAT, g, e_isdeq, e_err});
                if (e_enq) m_cnt++;
                if (e_deq) m_cnt--;
            end
            if (clear_i) begin
                m_cnt     = 0;
                m_q.delete();
                m_ok_at   = cyc + 1 + CLR_CYCLES;
                m_clr_end = m_ok_at;
            end
        end
        cyc++;
    endtask

    task automatic drive(logic r, logic c, logic [1:0] v, logic [1:0] o,
                         logic [15:0] d0, logic [15:0] d1, logic [15:0] chn);
        reset_i      = r;
        clear_i      = c;
        req_valid_i  = v;
        req_op_i     = o;
        req_data_i   = {d1, d0};
        chain_data_i = chn;
    endtask

    task automatic cycle(logic r, logic c, logic [1:0] v, logic [1:0] o,
                         logic [15:0] d0, logic [15:0] d1, logic [15:0] chn);
        drive(r, c, v, o, d0, d1, chn);
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic rst, clr; logic [1:0] vld, op; logic [15:0] d0, chn;
        logic [1:0] gnt; logic enq, deq; logic [15:0] data;
        logic rv, rid, rerr; logic [15:0] rdata; logic [6:0] cnt; logic busy, cres;
    } vec_t;

    function automatic vec_t mk(logic r, logic c, logic [1:0] v, logic [1:0] o,
                                logic [15:0] d0, logic [15:0] chn, logic [1:0] gn,
                                logic en, logic de, logic [15:0] dat, logic rv,
                                logic rid, logic re, logic [15:0] rd, logic [6:0] cn,
                                logic bu, logic cr);
        return '{r, c, v, o, d0, chn, gn, en, de, dat, rv, rid, re, rd, cn, bu, cr};
    endfunction

    vec_t tbl[22];

    initial begin
        int base_g, base_r, bound;

        // Reset, clear window, enq/deq pair, deq-while-empty from both requesters.
        tbl[0]  = mk(1'b1,1'b0,2'b00,2'b00,16'h0005,16'h1234, 2'b00,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b1,1'b1);
        tbl[1]  = tbl[0];
        for (int i = 2; i < 10; i++)
            tbl[i] = mk(1'b0,1'b0,2'b01,2'b00,16'h0005,16'h1234, 2'b00,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b1,1'b1);
        tbl[10] = mk(1'b0,1'b0,2'b01,2'b00,16'h0005,16'h1234, 2'b01,1'b1,1'b0,16'h0005, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b0,1'b0);
        tbl[11] = mk(1'b0,1'b0,2'b01,2'b01,16'h0005,16'h1234, 2'b00,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd1,1'b1,1'b0);
        tbl[12] = mk(1'b0,1'b0,2'b01,2'b01,16'h0005,16'h1234, 2'b01,1'b0,1'b1,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd1,1'b0,1'b0);
        tbl[13] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'h1234, 2'b00,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,16'h0000, 7'd0,1'b1,1'b0);
        tbl[14] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'h1234, 2'b00,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b0,1'b0);
        tbl[15] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'h0005, 2'b00,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,16'h0005, 7'd0,1'b0,1'b0);
        tbl[16] = mk(1'b0,1'b0,2'b01,2'b01,16'h0005,16'hBEEF, 2'b01,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b0,1'b0);
        tbl[17] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'hBEEF, 2'b00,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b1,1'b0);
        tbl[18] = mk(1'b0,1'b0,2'b10,2'b10,16'h0005,16'hBEEF, 2'b10,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b0,1'b0);
        tbl[19] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'hBEEF, 2'b00,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b1,16'h0000, 7'd0,1'b1,1'b0);
        tbl[20] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'hBEEF, 2'b00,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0000, 7'd0,1'b0,1'b0);
        tbl[21] = mk(1'b0,1'b0,2'b00,2'b00,16'h0005,16'hBEEF, 2'b00,1'b0,1'b0,16'h0000, 1'b1,1'b1,1'b1,16'h0000, 7'd0,1'b0,1'b0);

        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].op, tbl[i].d0, 16'h0007, tbl[i].chn);
            @(negedge clk);
            model_step();
            check("tbl_grant", grant_o, tbl[i].gnt);
            check("tbl_enq", enq_o, tbl[i].enq);
            check("tbl_deq", deq_o, tbl[i].deq);
            check("tbl_data", data_o, tbl[i].data);
            check("tbl_rsp_valid", rsp_valid_o, tbl[i].rv);
            check("tbl_rsp_id", rsp_id_o, tbl[i].rid);
            check("tbl_rsp_err", rsp_err_o, tbl[i].rerr);
            check("tbl_rsp_data", rsp_data_o, tbl[i].rdata);
            check("tbl_count", count_o, tbl[i].cnt);
            check("tbl_busy", busy_o, tbl[i].busy);
            check("tbl_chain_reset", chain_reset_o, tbl[i].cres);
            check("tbl_empty", empty_o, tbl[i].cnt == 7'd0);
            @(posedge clk);
            #1;
        end

        // Both requesters enqueue continuously: four alternating grants in eight cycles.
        base_g = gnt_seen;
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 2'b11, 2'b00, 16'($urandom), 16'($urandom), 16'h0);
        check("alt_grant_count", gnt_seen - base_g, 4);

        // Fill to capacity, then enqueue into a full chain.
        bound = 0;
        while (m_cnt < CAPACITY && bound < 200) begin
            cycle(1'b0, 1'b0, 2'b01, 2'b00, 16'($urandom), 16'h0, 16'h0);
            bound++;
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 2'b01, 2'b00, 16'h00AA, 16'h0, 16'h0);
        check("full_after_fill", full_o, 1'b1);
        check("count_after_fill", count_o, 7'd64);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0);

        // clear_i one cycle after a deq grant drops that response.
        bound = 0;
        do begin
            cycle(1'b0, 1'b0, 2'b01, 2'b01, 16'h0, 16'h0, 16'h4321);
            bound++;
        end while (!last_grant && bound < 4);
        check("deq_grant_seen", last_grant, 1'b1);
        base_r = rsp_seen;
        cycle(1'b0, 1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 16'h4321);
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h4321);
        check("clear_drops_rsp", rsp_seen - base_r, 0);
        check("count_after_clear", count_o, 7'd0);

        // reset_i in the gap after a grant, with its response still in flight.
        bound = 0;
        do begin
            cycle(1'b0, 1'b0, 2'b10, 2'b00, 16'h0, 16'h1111, 16'h0);
            bound++;
        end while (!last_grant && bound < 4);
        check("enq_grant_seen", last_grant, 1'b1);
        cycle(1'b1, 1'b0, 2'b11, 2'b00, 16'h0, 16'h1111, 16'h0);
        base_r = rsp_seen;
        for (int i = 0; i < 14; i++)
            cycle(1'b0, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0);
        check("reset_drops_rsp", rsp_seen - base_r, 0);

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 900; i++)
            cycle($urandom_range(299) == 0, $urandom_range(79) == 0,
                  2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
